// File: rtl/vram_bank_array_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_bank_array_if
// Purpose  : Command/response bundle for the two VRAM ports and clear engine.
// Revision : 1.0 - initial release
// ============================================================================
interface vram_bank_array_if #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 9
);
    localparam int C_BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [C_BSEL_W-1:0] a_bank;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_wrdata;
    logic [DATA_W/8-1:0] a_byteen;
    logic                a_wren;
    logic                a_rden;
    logic [DATA_W-1:0]   a_rddata;
    logic                a_rdvalid;

    logic [C_BSEL_W-1:0] b_bank;
    logic [ADDR_W-1:0]   b_addr;
    logic [DATA_W-1:0]   b_wrdata;
    logic [DATA_W/8-1:0] b_byteen;
    logic                b_wren;
    logic                b_rden;
    logic [DATA_W-1:0]   b_rddata;
    logic                b_rdvalid;
    logic                b_ready;

    logic                clr_start;
    logic [C_BSEL_W-1:0] clr_bank;
    logic                clr_busy;
    logic                clr_done;
    logic                collision;

    modport master (
        output a_bank, a_addr, a_wrdata, a_byteen, a_wren, a_rden,
        output b_bank, b_addr, b_wrdata, b_byteen, b_wren, b_rden,
        output clr_start, clr_bank,
        input  a_rddata, a_rdvalid, b_rddata, b_rdvalid, b_ready,
        input  clr_busy, clr_done, collision
    );

    modport slave (
        input  a_bank, a_addr, a_wrdata, a_byteen, a_wren, a_rden,
        input  b_bank, b_addr, b_wrdata, b_byteen, b_wren, b_rden,
        input  clr_start, clr_bank,
        output a_rddata, a_rdvalid, b_rddata, b_rdvalid, b_ready,
        output clr_busy, clr_done, collision
    );
endinterface
`default_nettype wire

// File: rtl/vram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : vram_bank_array
// Purpose  : NUM_BANKS true-dual-port byte-writable VRAM banks with read
//            pipeline, write-collision arbitration and a bank-clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module vram_bank_array #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 9,
    parameter int OUT_REG   = 1
) (
    input  logic             clk,
    input  logic             reset,
    vram_bank_array_if.slave bus
);
    localparam int C_BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int C_NBYTES = DATA_W / 8;
    localparam int C_DEPTH  = 1 << ADDR_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [C_BSEL_W-1:0] r_clr_bank;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_clr_done;
    logic                r_collision;

    // Effective per-port commands: index 0 is port A, index 1 is port B
    logic [C_BSEL_W-1:0] w_bank  [2];
    logic [ADDR_W-1:0]   w_addr  [2];
    logic [DATA_W-1:0]   w_wdata [2];
    logic [C_NBYTES-1:0] w_be    [2];
    logic                w_we    [2];
    logic                w_rd    [2];
    logic [C_NBYTES-1:0] w_b_be_raw;
    logic                w_clearing;
    logic                w_same_word;
    logic                w_collide;

    logic [DATA_W-1:0]   w_bank_q [2][NUM_BANKS];
    logic [DATA_W-1:0]   w_rdd    [2];
    logic                w_rdv    [2];

    function automatic logic in_range(input logic [C_BSEL_W-1:0] bank);
        return {1'b0, bank} < (C_BSEL_W+1)'(NUM_BANKS);
    endfunction

    always_comb begin
        w_clearing = (r_state == S_CLEAR);

        w_bank[0]  = bus.a_bank;
        w_addr[0]  = bus.a_addr;
        w_wdata[0] = bus.a_wrdata;
        w_be[0]    = bus.a_byteen;
        w_we[0]    = bus.a_wren;
        w_rd[0]    = bus.a_rden;

        // The clear engine owns port B; its write is held off during reset so
        // an aborted clear leaves the current address untouched.
        if (w_clearing) begin
            w_bank[1]  = r_clr_bank;
            w_addr[1]  = r_clr_cnt;
            w_wdata[1] = '0;
            w_b_be_raw = '1;
            w_we[1]    = !reset;
            w_rd[1]    = 1'b0;
        end else begin
            w_bank[1]  = bus.b_bank;
            w_addr[1]  = bus.b_addr;
            w_wdata[1] = bus.b_wrdata;
            w_b_be_raw = bus.b_byteen;
            w_we[1]    = bus.b_wren;
            w_rd[1]    = bus.b_rden;
        end

        w_same_word = bus.a_wren && w_we[1] &&
                      (bus.a_bank == w_bank[1]) && (bus.a_addr == w_addr[1]);
        w_be[1]     = w_same_word ? (w_b_be_raw & ~bus.a_byteen) : w_b_be_raw;
        w_collide   = w_same_word && !w_clearing && in_range(bus.a_bank);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_clr_bank  <= '0;
            r_clr_cnt   <= '0;
            r_clr_done  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_clr_done  <= 1'b0;
            r_collision <= w_collide;
            case (r_state)
                S_IDLE: begin
                    if (bus.clr_start && in_range(bus.clr_bank)) begin
                        r_state    <= S_CLEAR;
                        r_clr_bank <= bus.clr_bank;
                        r_clr_cnt  <= '0;
                    end
                end
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == '1) begin
                        r_state    <= S_IDLE;
                        r_clr_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_W-1:0] r_mem [C_DEPTH];
        logic [DATA_W-1:0] r_q   [2];
        logic              w_sel_we [2];
        logic              w_sel_rd [2];

        for (genvar p = 0; p < 2; p++) begin : g_pt
            assign w_sel_we[p]    = w_we[p] && (w_bank[p] == C_BSEL_W'(g));
            assign w_sel_rd[p]    = w_rd[p] && (w_bank[p] == C_BSEL_W'(g));
            assign w_bank_q[p][g] = r_q[p];
        end

        // Port B lanes overlapping port A are already masked, so the two
        // write loops never target the same byte.
        always_ff @(posedge clk) begin
            for (int p = 0; p < 2; p++) begin
                if (w_sel_rd[p]) begin
                    r_q[p] <= r_mem[w_addr[p]];
                end
                if (w_sel_we[p]) begin
                    for (int i = 0; i < C_NBYTES; i++) begin
                        if (w_be[p][i]) begin
                            r_mem[w_addr[p]][i*8 +: 8] <= w_wdata[p][i*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                r_v1;
        logic                r_inr1;
        logic [C_BSEL_W-1:0] r_bsel1;
        logic [DATA_W-1:0]   w_d1;

        // Bank select is captured only on a read, so the muxed bank output
        // holds the last result while no read is in flight.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_v1    <= 1'b0;
                r_inr1  <= 1'b0;
                r_bsel1 <= '0;
            end else begin
                r_v1 <= w_rd[p];
                if (w_rd[p]) begin
                    r_inr1  <= in_range(w_bank[p]);
                    r_bsel1 <= w_bank[p];
                end
            end
        end

        always_comb begin
            w_d1 = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_inr1 && (r_bsel1 == C_BSEL_W'(b))) begin
                    w_d1 = w_bank_q[p][b];
                end
            end
        end

        if (OUT_REG != 0) begin : g_out_reg
            logic              r_v2;
            logic [DATA_W-1:0] r_d2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= w_d1;
                    end
                end
            end

            assign w_rdv[p] = r_v2;
            assign w_rdd[p] = r_d2;
        end else begin : g_no_out_reg
            assign w_rdv[p] = r_v1;
            assign w_rdd[p] = w_d1;
        end
    end

    assign bus.a_rddata  = w_rdd[0];
    assign bus.a_rdvalid = w_rdv[0];
    assign bus.b_rddata  = w_rdd[1];
    assign bus.b_rdvalid = w_rdv[1];
    assign bus.b_ready   = (r_state == S_IDLE);
    assign bus.clr_busy  = (r_state == S_CLEAR);
    assign bus.clr_done  = r_clr_done;
    assign bus.collision = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_vram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_bank_array
// Purpose  : Directed scoreboard bench for vram_bank_array, OUT_REG 0 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_bank_array;
    localparam int NB    = 3;
    localparam int DW    = 128;
    localparam int AW    = 4;
    localparam int NBY   = DW / 8;
    localparam int DEPTH = 1 << AW;

    localparam logic [DW-1:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_AA55;
    localparam logic [DW-1:0] D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [DW-1:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C;
    localparam logic [DW-1:0] D4 = 128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0;
    localparam logic [DW-1:0] D5 = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [DW-1:0] D6 = 128'h6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    localparam logic [DW-1:0] D7 = 128'h7777_7777_7777_7777_7777_7777_7777_7777;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]     a_bank = '0, b_bank = '0, clr_bank = '0;
    logic [AW-1:0]  a_addr = '0, b_addr = '0;
    logic [DW-1:0]  a_wrdata = '0, b_wrdata = '0;
    logic [NBY-1:0] a_byteen = '0, b_byteen = '0;
    logic a_wren = 1'b0, a_rden = 1'b0, b_wren = 1'b0, b_rden = 1'b0, clr_start = 1'b0;

    vram_bank_array_if #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) bus0 ();
    vram_bank_array_if #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.a_bank = a_bank;     assign bus1.a_bank = a_bank;
    assign bus0.a_addr = a_addr;     assign bus1.a_addr = a_addr;
    assign bus0.a_wrdata = a_wrdata; assign bus1.a_wrdata = a_wrdata;
    assign bus0.a_byteen = a_byteen; assign bus1.a_byteen = a_byteen;
    assign bus0.a_wren = a_wren;     assign bus1.a_wren = a_wren;
    assign bus0.a_rden = a_rden;     assign bus1.a_rden = a_rden;
    assign bus0.b_bank = b_bank;     assign bus1.b_bank = b_bank;
    assign bus0.b_addr = b_addr;     assign bus1.b_addr = b_addr;
    assign bus0.b_wrdata = b_wrdata; assign bus1.b_wrdata = b_wrdata;
    assign bus0.b_byteen = b_byteen; assign bus1.b_byteen = b_byteen;
    assign bus0.b_wren = b_wren;     assign bus1.b_wren = b_wren;
    assign bus0.b_rden = b_rden;     assign bus1.b_rden = b_rden;
    assign bus0.clr_start = clr_start; assign bus1.clr_start = clr_start;
    assign bus0.clr_bank = clr_bank;   assign bus1.clr_bank = clr_bank;

    vram_bank_array #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    vram_bank_array #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    // Observation slots: 0/1 = dut0 A/B, 2/3 = dut1 A/B
    logic          obs_v [4];
    logic [DW-1:0] obs_d [4];
    logic          obs_rdy [2], obs_busy [2], obs_done [2], obs_coll [2];
    assign obs_v[0] = bus0.a_rdvalid; assign obs_d[0] = bus0.a_rddata;
    assign obs_v[1] = bus0.b_rdvalid; assign obs_d[1] = bus0.b_rddata;
    assign obs_v[2] = bus1.a_rdvalid; assign obs_d[2] = bus1.a_rddata;
    assign obs_v[3] = bus1.b_rdvalid; assign obs_d[3] = bus1.b_rddata;
    assign obs_rdy[0] = bus0.b_ready;     assign obs_rdy[1] = bus1.b_ready;
    assign obs_busy[0] = bus0.clr_busy;   assign obs_busy[1] = bus1.clr_busy;
    assign obs_done[0] = bus0.clr_done;   assign obs_done[1] = bus1.clr_done;
    assign obs_coll[0] = bus0.collision;  assign obs_coll[1] = bus1.collision;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;
    exp_t          sb [4][$];
    exp_t          mon_e;
    logic [DW-1:0] last_d [4];
    logic [DW-1:0] mdl [4][DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read-response monitor: pops scoreboard, checks data, latency and hold
    always @(negedge clk) begin
        if (obs_busy[0] === 1'b1) busy_cnt++;
        if (obs_done[0] === 1'b1) done_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                last_d[i] = '0;
            end else if (obs_v[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    chk("spurious_rdvalid", obs_v[i], 1'b0);
                end else begin
                    mon_e = sb[i].pop_front();
                    chk("rd_data", obs_d[i], mon_e.d);
                    chk("rd_latency", cyc, mon_e.due);
                end
                last_d[i] = obs_d[i];
            end else begin
                chk("rd_hold", obs_d[i], last_d[i]);
                if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                    chk("rd_missing", obs_v[i], 1'b1);
                    void'(sb[i].pop_front());
                end
            end
        end
    end

    function automatic logic [DW-1:0] pat(input int b, input int a);
        logic [7:0] x;
        x = 8'(a * 16 + b + 1);
        return {NBY{x}};
    endfunction

    function automatic logic [DW-1:0] mdl_rd(input int b, input int a);
        return (b < NB) ? mdl[b][a] : '0;
    endfunction

    task automatic mdl_wr(input int b, input int a, input logic [DW-1:0] d, input logic [NBY-1:0] be);
        if (b < NB) begin
            for (int i = 0; i < NBY; i++) begin
                if (be[i]) mdl[b][a][i*8 +: 8] = d[i*8 +: 8];
            end
        end
    endtask

    task automatic exp_rd(input int port, input logic [DW-1:0] d);
        exp_t e;
        e.d = d;
        e.due = cyc + 1;
        sb[port].push_back(e);
        e.due = cyc + 2;
        sb[2 + port].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        tick();
        a_wren = 1'b0; a_rden = 1'b0; b_wren = 1'b0; b_rden = 1'b0; clr_start = 1'b0;
    endtask

    task automatic set_wr_a(input int b, input int a, input logic [DW-1:0] d, input logic [NBY-1:0] be);
        a_bank = 2'(b); a_addr = AW'(a); a_wrdata = d; a_byteen = be; a_wren = 1'b1;
        mdl_wr(b, a, d, be);
    endtask

    task automatic set_wr_b(input int b, input int a, input logic [DW-1:0] d, input logic [NBY-1:0] be);
        b_bank = 2'(b); b_addr = AW'(a); b_wrdata = d; b_byteen = be; b_wren = 1'b1;
        mdl_wr(b, a, d, be);
    endtask

    task automatic set_rd_a(input int b, input int a, input logic [DW-1:0] exp);
        a_bank = 2'(b); a_addr = AW'(a); a_rden = 1'b1;
        exp_rd(0, exp);
    endtask

    task automatic set_rd_b(input int b, input int a, input logic [DW-1:0] exp);
        b_bank = 2'(b); b_addr = AW'(a); b_rden = 1'b1;
        exp_rd(1, exp);
    endtask

    initial begin
        logic got;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_a_rdvalid", obs_v[2*k], 1'b0);
            chk("rst_b_rdvalid", obs_v[2*k+1], 1'b0);
            chk("rst_a_rddata", obs_d[2*k], '0);
            chk("rst_b_rddata", obs_d[2*k+1], '0);
            chk("rst_b_ready", obs_rdy[k], 1'b1);
            chk("rst_clr_busy", obs_busy[k], 1'b0);
            chk("rst_clr_done", obs_done[k], 1'b0);
            chk("rst_collision", obs_coll[k], 1'b0);
        end
        reset = 1'b0;

        // Cross-port write then read
        set_wr_a(2, 5, D1, '1); cycle();
        set_rd_b(2, 5, D1); cycle();
        set_rd_a(2, 5, D1); cycle();

        // Single byte-lane write
        set_wr_a(0, 3, '1, '1); cycle();
        set_wr_a(0, 3, '0, 16'h0001); cycle();
        set_rd_a(0, 3, {{120{1'b1}}, 8'h00}); cycle();

        // Same-cycle read and write return the old word on both ports
        set_rd_a(0, 3, {{120{1'b1}}, 8'h00});
        set_rd_b(0, 3, {{120{1'b1}}, 8'h00});
        set_wr_a(0, 3, D2, '1); cycle();
        set_rd_b(0, 3, D2); cycle();

        // Write collision: port A owns its lanes
        set_wr_b(1, 9, {NBY{8'h22}}, '1);
        set_wr_a(1, 9, {NBY{8'h11}}, 16'h00FF); cycle();
        for (int k = 0; k < 2; k++) chk("collision_pulse", obs_coll[k], 1'b1);
        set_rd_a(1, 9, {{8{8'h22}}, {8{8'h11}}}); cycle();
        for (int k = 0; k < 2; k++) chk("collision_end", obs_coll[k], 1'b0);
        set_wr_a(1, 10, D3, '1); set_wr_b(1, 11, D4, '1); cycle();
        for (int k = 0; k < 2; k++) chk("collision_diff_addr", obs_coll[k], 1'b0);

        // Out-of-range bank
        set_wr_a(0, 5, D3, '1); set_wr_b(1, 5, D4, '1); cycle();
        set_wr_a(3, 5, D5, '1); set_wr_b(3, 6, D5, '1); cycle();
        set_rd_a(3, 5, '0); set_rd_b(0, 5, mdl_rd(0, 5)); cycle();
        set_rd_a(1, 5, mdl_rd(1, 5)); set_rd_b(2, 5, mdl_rd(2, 5)); cycle();

        // Pre-fill banks 0 and 1, then clear bank 1
        for (int a = 0; a < DEPTH; a++) begin
            set_wr_a(1, a, pat(1, a), '1); set_wr_b(0, a, pat(0, a), '1); cycle();
        end
        repeat (3) tick();
        busy_cnt = 0; done_cnt = 0;
        clr_bank = 2'd1; clr_start = 1'b1; cycle();
        for (int k = 0; k < 2; k++) begin
            chk("clr_busy_start", obs_busy[k], 1'b1);
            chk("b_ready_low", obs_rdy[k], 1'b0);
        end
        for (int a = 0; a < DEPTH; a++) mdl[1][a] = '0;
        set_wr_a(1, 0, D6, '1);
        b_bank = 2'd0; b_addr = '0; b_wrdata = D7; b_byteen = '1; b_wren = 1'b1; b_rden = 1'b1;
        cycle();
        for (int k = 0; k < 2; k++) chk("clr_collision_quiet", obs_coll[k], 1'b0);
        clr_bank = 2'd0; clr_start = 1'b1; cycle();
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (obs_done[0] === 1'b1) got = 1'b1;
            else tick();
        end
        chk("clr_done_seen", got, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("clr_done", obs_done[k], 1'b1);
            chk("clr_busy_end", obs_busy[k], 1'b0);
            chk("b_ready_end", obs_rdy[k], 1'b1);
        end
        chk("clr_busy_cycles", busy_cnt, 16);
        tick();
        for (int k = 0; k < 2; k++) chk("clr_done_pulse", obs_done[k], 1'b0);
        chk("clr_done_count", done_cnt, 1);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd_a(1, a, mdl_rd(1, a)); set_rd_b(0, a, mdl_rd(0, a)); cycle();
        end

        // Out-of-range clear request is ignored
        clr_bank = 2'd3; clr_start = 1'b1; cycle();
        for (int k = 0; k < 2; k++) begin
            chk("clr_oor_busy", obs_busy[k], 1'b0);
            chk("clr_oor_ready", obs_rdy[k], 1'b1);
        end

        // Reset during clear cycle 7
        for (int a = 0; a < DEPTH; a++) begin
            set_wr_a(1, a, pat(5, a), '1); cycle();
        end
        repeat (3) tick();
        clr_bank = 2'd1; clr_start = 1'b1; cycle();
        repeat (7) tick();
        done_cnt = 0;
        reset = 1'b1; tick();
        for (int k = 0; k < 2; k++) begin
            chk("abort_busy", obs_busy[k], 1'b0);
            chk("abort_ready", obs_rdy[k], 1'b1);
            chk("abort_done", obs_done[k], 1'b0);
        end
        reset = 1'b0;
        for (int a = 0; a < 7; a++) mdl[1][a] = '0;
        repeat (20) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", obs_busy[1], 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd_b(1, a, mdl_rd(1, a)); cycle();
        end
        repeat (4) tick();
        for (int i = 0; i < 4; i++) chk("sb_drained", sb[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vram_bank_array.md
# vram_bank_array

Parametrised multi-bank true-dual-port VRAM for the CPU-facing side of the PPU. Generalises the fixed four-RAM CPU-facing VRAM to NUM_BANKS inferred banks of configurable width and depth, each addressed through two bank-selecting ports. Adds per-byte write enables, read-valid tracking with an optional output register, deterministic same-address write-collision resolution, and a hardware bank-clear engine that zero-fills one bank while the DMA-Engine stays on port A.

## Interface
- NUM_BANKS, 4, number of banks (tile, pattern, palette, sprite by default); ≥1
- DATA_W, 128, word width in bits; multiple of 8
- ADDR_W, 9, word address width; bank depth = 2**ADDR_W
- OUT_REG, 1, 0 or 1; adds an output register stage to read data
- BSEL_W is derived: max(1, $clog2(NUM_BANKS))

- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- a_bank  in  BSEL_W  port A bank select
- a_addr  in  ADDR_W  port A word address
- a_wrdata  in  DATA_W  port A write data
- a_byteen  in  DATA_W/8  port A byte enables
- a_wren  in  1  port A write strobe
- a_rden  in  1  port A read strobe
- a_rddata  out  DATA_W  port A read data
- a_rdvalid  out  1  port A read data valid
- b_* (b_bank, b_addr, b_wrdata, b_byteen, b_wren, b_rden, b_rddata, b_rdvalid)  same as port A
- b_ready  out  1  port B accepts commands; low while clear is active
- clr_start  in  1  start zero-fill of clr_bank (pulse)
- clr_bank  in  BSEL_W  bank to clear, sampled with clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse on clear completion
- collision  out  1  one-cycle pulse: both ports wrote same bank/address

## Operation
- Bank select out of range (≥ NUM_BANKS): writes dropped, reads return 0 with rdvalid still asserted.
- Writes: byte lane i of addressed word updated iff wren and byteen[i]; other lanes unchanged.
- Reads: rden captures the word; same-port or cross-port write to the same address in the same cycle returns old data.
- Simultaneous wren and rden on one port: both performed; read returns old data.
- Collision (a_wren, b_wren, a_bank==b_bank, a_addr==b_addr): port A wins overlapping lanes; port B byte enables masked by ~a_byteen; collision pulses next cycle.
- Clear engine states: IDLE, CLEAR. IDLE→CLEAR on clr_start (latch clr_bank, counter=0, clr_busy=1, b_ready=0). CLEAR: each cycle writes all-zero, all-byte word at counter via port B of latched bank; counter increments. After writing address 2**ADDR_W−1 → IDLE, clr_done pulses, clr_busy and b_ready restored.
- Port B commands while b_ready=0 are ignored (no write, no rdvalid). Port A unaffected, including writes to the bank being cleared; port A write to the address being cleared that cycle wins (collision does not pulse).
- clr_start in CLEAR ignored. clr_start with out-of-range clr_bank ignored.
- RAM contents not initialised or altered by reset.

## Timing
- Read latency: rdvalid/rddata valid 1+OUT_REG cycles after rden sampled; fully pipelined, one read per port per cycle.
- rddata holds last value when rdvalid low.
- Write visible to reads issued the following cycle.
- Clear: clr_busy high from cycle after clr_start for exactly 2**ADDR_W cycles; clr_done in the cycle clr_busy falls; b_ready high same cycle.
- Reset values: a_rddata, b_rddata = 0; a_rdvalid, b_rdvalid = 0; b_ready = 1; clr_busy = 0; clr_done = 0; collision = 0; state IDLE. Pipelined reads in flight at reset discarded.
- Reset mid-clear: abort immediately, bank left partially cleared, no clr_done.

## Test plan
- Port A write bank 2 addr 0x05 data 0x…AA55, byteen all ones; port B read bank 2 addr 0x05 next cycle -> b_rdvalid and data 0x…AA55 after 1+OUT_REG cycles.
- Byte-enable: word 0xFF…FF, then write 0x00…00 with byteen 0x0001 -> readback 0xFF…FF00.
- Collision: A writes 0x11…11 byteen 0x00FF, B writes 0x22…22 byteen 0xFFFF, same bank/addr -> collision pulse, readback upper 8 bytes 0x22, lower 8 bytes 0x11.
- Clear bank 1 (ADDR_W=4 build) pre-filled with nonzero -> clr_busy 16 cycles, clr_done pulse, all 16 words read 0; bank 0 unchanged; port B writes during clear dropped.
- Reset asserted at clear cycle 7 -> clr_busy 0 and b_ready 1 next cycle, no clr_done, addresses 0-6 zero, 7-15 unchanged.
- Out-of-range bank (NUM_BANKS=3, bank=3) write then read -> no bank modified, readback 0 with rdvalid.
